// File: rtl/dpc_frame_ctrl.sv
// Frame-synchronous controller for the Bayer defective-pixel-correction stage.
// Shadows host configuration, commits it at frame start and reports per-frame statistics.
module dpc_frame_ctrl #(
   parameter int TH_DEFAULT = 150,
   parameter int CNT_W      = 20,
   parameter int LINE_W     = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_wr,
   input  logic [1:0]        cfg_addr,
   input  logic [15:0]       cfg_wdata,
   input  logic              per_img_vsync,
   input  logic              per_img_de,
   input  logic              corr_flag,
   output logic              dpc_en,
   output logic [7:0]        dpc_th,
   output logic              busy,
   output logic [15:0]       frame_cnt,
   output logic              stat_valid,
   output logic [CNT_W-1:0]  stat_corr_cnt,
   output logic [LINE_W-1:0] stat_line_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_ACTIVE = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   localparam logic [7:0]        TH_RST   = 8'(TH_DEFAULT);
   localparam logic [CNT_W-1:0]  CORR_MAX = {CNT_W{1'b1}};
   localparam logic [LINE_W-1:0] LINE_MAX = {LINE_W{1'b1}};

   state_t              state_q, state_d;
   logic                vs_q, vs_d;
   logic                de_q, de_d;
   logic                run_q, run_d;
   logic                sh_en_q, sh_en_d;
   logic [7:0]          sh_th_q, sh_th_d;
   logic                dpc_en_q, dpc_en_d;
   logic [7:0]          dpc_th_q, dpc_th_d;
   logic [CNT_W-1:0]    corr_q, corr_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [CNT_W-1:0]    stat_corr_q, stat_corr_d;
   logic [LINE_W-1:0]   stat_line_q, stat_line_d;
   logic                stat_valid_q, stat_valid_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;

   logic vs_rise, vs_fall, de_fall, clr_wr;
   logic unused_wdata;

   function automatic logic [CNT_W-1:0] corr_sat_inc(input logic [CNT_W-1:0] v);
      return (v == CORR_MAX) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [LINE_W-1:0] line_sat_inc(input logic [LINE_W-1:0] v);
      return (v == LINE_MAX) ? v : v + LINE_W'(1);
   endfunction

   assign vs_rise      = per_img_vsync & ~vs_q;
   assign vs_fall      = ~per_img_vsync & vs_q;
   assign de_fall      = ~per_img_de & de_q;
   assign clr_wr       = cfg_wr && (cfg_addr == 2'd2);
   assign unused_wdata = ^cfg_wdata[15:8];

   always_comb begin
      state_d      = state_q;
      vs_d         = per_img_vsync;
      de_d         = per_img_de;
      run_d        = run_q;
      sh_en_d      = sh_en_q;
      sh_th_d      = sh_th_q;
      dpc_en_d     = dpc_en_q;
      dpc_th_d     = dpc_th_q;
      corr_d       = corr_q;
      line_d       = line_q;
      stat_corr_d  = stat_corr_q;
      stat_line_d  = stat_line_q;
      stat_valid_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;

      if (cfg_wr) begin
         case (cfg_addr)
            2'd0: begin
               run_d   = cfg_wdata[0];
               sh_en_d = cfg_wdata[1];
            end
            2'd1:    sh_th_d = cfg_wdata[7:0];
            default: ;
         endcase
      end

      // Commit reads the registered shadow, so a write landing on vs_rise waits a frame.
      case (state_q)
         S_IDLE: begin
            dpc_en_d = 1'b0;
            if (run_q) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (!run_q) begin
               state_d = S_IDLE;
            end else if (vs_rise) begin
               dpc_en_d = sh_en_q;
               dpc_th_d = sh_th_q;
               corr_d   = '0;
               line_d   = '0;
               state_d  = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (corr_flag) corr_d = corr_sat_inc(corr_q);
            if (de_fall)   line_d = line_sat_inc(line_q);
            if (vs_fall)   state_d = S_REPORT;
         end
         S_REPORT: begin
            stat_corr_d  = corr_q;
            stat_line_d  = line_q;
            stat_valid_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = run_q ? S_ARMED : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (clr_wr) frame_cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         vs_q         <= vs_d;
         de_q         <= de_d;
         run_q        <= 1'b0;
         sh_en_q      <= 1'b0;
         sh_th_q      <= TH_RST;
         dpc_en_q     <= 1'b0;
         dpc_th_q     <= TH_RST;
         corr_q       <= '0;
         line_q       <= '0;
         stat_corr_q  <= '0;
         stat_line_q  <= '0;
         stat_valid_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         vs_q         <= vs_d;
         de_q         <= de_d;
         run_q        <= run_d;
         sh_en_q      <= sh_en_d;
         sh_th_q      <= sh_th_d;
         dpc_en_q     <= dpc_en_d;
         dpc_th_q     <= dpc_th_d;
         corr_q       <= corr_d;
         line_q       <= line_d;
         stat_corr_q  <= stat_corr_d;
         stat_line_q  <= stat_line_d;
         stat_valid_q <= stat_valid_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign dpc_en        = dpc_en_q;
   assign dpc_th        = dpc_th_q;
   assign busy          = (state_q == S_ACTIVE);
   assign frame_cnt     = frame_cnt_q;
   assign stat_valid    = stat_valid_q;
   assign stat_corr_cnt = stat_corr_q;
   assign stat_line_cnt = stat_line_q;

endmodule

// File: tb/tb_dpc_frame_ctrl.sv
// Directed/randomized bench for dpc_frame_ctrl against a frame-level reference model.
// Narrow counters keep the saturation frames short.
module tb_dpc_frame_ctrl;

   localparam int TH_DEF = 150;
   localparam int CW     = 10;
   localparam int LW     = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_wr;
   logic [1:0]    cfg_addr;
   logic [15:0]   cfg_wdata;
   logic          vs, de, cf;
   logic          dpc_en;
   logic [7:0]    dpc_th;
   logic          busy;
   logic [15:0]   frame_cnt;
   logic          stat_valid;
   logic [CW-1:0] stat_corr_cnt;
   logic [LW-1:0] stat_line_cnt;

   dpc_frame_ctrl #(.TH_DEFAULT(TH_DEF), .CNT_W(CW), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .per_img_vsync(vs), .per_img_de(de), .corr_flag(cf),
      .dpc_en(dpc_en), .dpc_th(dpc_th), .busy(busy), .frame_cnt(frame_cnt),
      .stat_valid(stat_valid), .stat_corr_cnt(stat_corr_cnt), .stat_line_cnt(stat_line_cnt)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int n_pulse  = 0;

   // reference model: shadow, active, and report bookkeeping
   bit m_run, m_en, a_en;
   int m_th, a_th, m_frames, m_pulses, e_corr, e_line;

   always @(negedge clk) if (stat_valid === 1'b1) n_pulse++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_run = 0; m_en = 0; m_th = TH_DEF;
      a_en = 0; a_th = TH_DEF;
      m_frames = 0; e_corr = 0; e_line = 0;
   endtask

   task automatic model_wr(input logic [1:0] a, input logic [15:0] d);
      case (a)
         2'd0: begin m_run = d[0]; m_en = d[1]; end
         2'd1: m_th = int'(d[7:0]);
         2'd2: m_frames = 0;
         default: ;
      endcase
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      cfg_wr = 1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_wr = 0;
      model_wr(a, d);
   endtask

   task automatic check_outputs(input string nm);
      chk({nm, "_en"}, dpc_en, a_en);
      chk({nm, "_th"}, dpc_th, a_th);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_fcnt"}, frame_cnt, m_frames);
      chk({nm, "_corr"}, stat_corr_cnt, e_corr);
      chk({nm, "_line"}, stat_line_cnt, e_line);
      chk({nm, "_pulses"}, n_pulse, m_pulses);
      chk({nm, "_sv"}, stat_valid, 0);
   endtask

   task automatic frame(input string nm, input int lines, input int px, input int ncorr,
                        input bit cf_fall,
                        input bit wr_rise, input logic [1:0] ra, input logic [15:0] rd,
                        input bit wr_mid, input logic [1:0] ma, input logic [15:0] md,
                        input bit clr_rep);
      bit capt;
      int sent, left;
      vs = 0; de = 0; cf = 0;
      repeat (3) tick();
      chk({nm, "_pre_th"}, dpc_th, a_th);
      vs = 1;
      if (wr_rise) begin cfg_wr = 1; cfg_addr = ra; cfg_wdata = rd; end
      capt = m_run;
      if (capt) begin a_en = m_en; a_th = m_th; end
      tick();
      cfg_wr = 0;
      if (wr_rise) model_wr(ra, rd);
      chk({nm, "_rise_en"}, dpc_en, a_en);
      chk({nm, "_rise_th"}, dpc_th, a_th);
      chk({nm, "_rise_busy"}, busy, capt);
      sent = 0;
      for (int l = 0; l < lines; l++) begin
         de = 0; cf = 0;
         tick(); tick();
         for (int p = 0; p < px; p++) begin
            de = 1;
            left = (lines - l - 1) * px + (px - p);
            cf = (sent < ncorr) && ($urandom_range(0, 3) == 0 || left <= ncorr - sent);
            if (cf) sent++;
            if (wr_mid && l == 1 && p == 0) begin
               cfg_wr = 1; cfg_addr = ma; cfg_wdata = md;
            end
            tick();
            if (wr_mid && l == 1 && p == 0) begin
               cfg_wr = 0;
               model_wr(ma, md);
            end
         end
         if (wr_mid && l == 1) begin
            chk({nm, "_mid_th"}, dpc_th, a_th);
            chk({nm, "_mid_busy"}, busy, capt);
         end
      end
      de = 0; cf = 0;
      tick();
      vs = 0; cf = cf_fall;
      tick();
      cf = 0;
      if (clr_rep) begin cfg_wr = 1; cfg_addr = 2'd2; cfg_wdata = 16'h0000; end
      tick();
      cfg_wr = 0;
      if (capt) begin
         m_pulses++;
         e_corr = (sent + int'(cf_fall) > (1 << CW) - 1) ? (1 << CW) - 1 : sent + int'(cf_fall);
         e_line = (lines > (1 << LW) - 1) ? (1 << LW) - 1 : lines;
         m_frames = (m_frames + 1) % 65536;
      end
      if (clr_rep) m_frames = 0;
      if (capt && !m_run) a_en = 0;
      tick(); tick();
      check_outputs({nm, "_end"});
   endtask

   initial begin
      int lines, px;
      rst = 1; cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0; vs = 0; de = 0; cf = 0;
      model_reset();
      m_pulses = 0;
      repeat (3) tick();
      rst = 0;
      check_outputs("reset");

      // configure: writes update the shadow only
      wr(2'd0, 16'h0003);
      wr(2'd1, 16'h0064);
      tick();
      chk("cfg_no_commit_th", dpc_th, TH_DEF);
      chk("cfg_no_commit_en", dpc_en, 0);

      frame("f1", 8, 16, 5, 0, 0, 0, 0, 1, 2'd1, 16'h0028, 0);
      chk("f1_th_100", dpc_th, 100);
      frame("f2", 8, 16, 5, 0, 1, 2'd1, 16'h003C, 0, 0, 0, 0);
      chk("f2_th_40", dpc_th, 40);
      frame("f3", 8, 16, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("f3_th_60", dpc_th, 60);
      chk("f3_fcnt_3", frame_cnt, 3);

      // run cleared mid-frame: frame still reports, then idle with enable dropped
      frame("stoprun", 6, 10, $urandom_range(0, 30), 0, 0, 0, 0, 1, 2'd0, 16'h0002, 0);
      chk("stoprun_en_off", dpc_en, 0);

      // run set while a frame is already in progress: that frame is not joined
      vs = 1; repeat (3) tick();
      wr(2'd0, 16'h0003);
      for (int i = 0; i < 12; i++) begin
         de = i[1]; cf = i[0];
         tick();
         if (i % 4 == 3) chk("join_busy", busy, 0);
      end
      de = 0; cf = 0; vs = 0;
      repeat (4) tick();
      check_outputs("nojoin");
      frame("afterjoin", 5, 8, $urandom_range(0, 40), 1, 0, 0, 0, 0, 0, 0, 0);

      // saturating frame with a clear landing on the report cycle
      frame("sat", 20, 60, (1 << CW) + 3, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("sat_corr_max", stat_corr_cnt, (1 << CW) - 1);
      chk("sat_fcnt_clr", frame_cnt, 0);

      // randomized frames
      for (int k = 0; k < 4; k++) begin
         lines = $urandom_range(2, 15);
         px    = $urandom_range(4, 12);
         frame("rnd", lines, px, $urandom_range(0, lines * px), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 2'd1, 16'($urandom),
               1'b1, 2'($urandom_range(1, 3)), 16'($urandom), 0);
      end

      // reset in the middle of a frame
      vs = 0; repeat (3) tick();
      vs = 1; tick();
      chk("mid_busy", busy, 1);
      de = 1; cf = 1; repeat (5) tick();
      de = 0; cf = 0; tick();
      rst = 1; tick(); rst = 0;
      model_reset();
      check_outputs("midrst");
      de = 1; cf = 1; repeat (4) tick();
      de = 0; cf = 0; vs = 0; repeat (4) tick();
      check_outputs("midrst_after");
      frame("nocap", 4, 8, 10, 1, 0, 0, 0, 0, 0, 0, 0);
      wr(2'd0, 16'h0003);
      frame("rearm", 4, 8, 10, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("rearm_th", dpc_th, TH_DEF);
      chk("rearm_en", dpc_en, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dpc_frame_ctrl.md
Name: dpc_frame_ctrl

Overview:
- Frame-synchronous controller for the Bayer defective-pixel-correction stage.
- Holds host-written configuration in shadow registers and commits it to the datapath only at frame start, so enable and threshold never change mid-frame.
- Sequences the stage per frame, counts corrected pixels and lines, and posts a one-cycle statistics report at each frame end.
- Sits between the register bus and the correction datapath, in the ISP pixel-clock domain.

Parameters:
- TH_DEFAULT, 150, threshold loaded into shadow and active registers on reset.
- CNT_W, 20, width of the corrected-pixel counter.
- LINE_W, 12, width of the line counter.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- cfg_wr  in  1  register write strobe, one write per cycle.
- cfg_addr  in  2  0=CTRL {bit1 dpc_en, bit0 run}, 1=TH[7:0], 2=CLR (any write clears frame_cnt), 3 reserved (write ignored).
- cfg_wdata  in  16  write data.
- per_img_vsync  in  1  high for the whole frame.
- per_img_de  in  1  pixel valid.
- corr_flag  in  1  datapath pulse, one per corrected pixel.
- dpc_en  out  1  active enable to the datapath.
- dpc_th  out  8  active threshold to the datapath.
- busy  out  1  high in ACTIVE.
- frame_cnt  out  16  completed frames since reset/clear.
- stat_valid  out  1  one-cycle pulse at report.
- stat_corr_cnt  out  CNT_W  corrected pixels in the last frame.
- stat_line_cnt  out  LINE_W  lines in the last frame.

Behaviour:
- Reset (rst=1 at a clk edge) sets the following:
  - shadow run=0, dpc_en=0, TH=TH_DEFAULT.
  - dpc_en=0, dpc_th=TH_DEFAULT.
  - state IDLE, busy=0, stat_valid=0.
  - stat_corr_cnt=0, stat_line_cnt=0, frame_cnt=0, and all internal counters 0.
- Edge detection: vs_rise and vs_fall come from a one-cycle registered vsync; de_fall comes from a registered de. A rise is not detected on the first cycle after reset if vsync is already high.
- Register writes always update the shadow registers immediately. Active outputs change only at a commit.
- States:
  - IDLE: wait for shadow run=1, then go to ARMED.
  - ARMED: if shadow run=0, return to IDLE. On vs_rise: commit, clear the working counters, go to ACTIVE. A frame already in progress when ARMED is entered is never joined.
  - ACTIVE: busy=1. corr_flag increments the corr counter; it saturates at 2^CNT_W-1. de_fall increments the line counter; it saturates at 2^LINE_W-1. On vs_fall go to REPORT. Clearing run does not abort; the frame completes.
  - REPORT (1 cycle): latch the counters into stat_*, pulse stat_valid=1, frame_cnt+=1 (wraps at 0xFFFF). Next state is ARMED if shadow run=1, else IDLE.
- Commit means dpc_en<=shadow dpc_en and dpc_th<=shadow TH, both valid from the cycle after vs_rise. In IDLE, dpc_en is forced to 0 the cycle after entry; dpc_th holds.
- cfg_wr coincident with vs_rise: the commit uses the pre-write shadow value. The new value takes effect at the next frame.
- corr_flag coincident with vs_fall is counted. corr_flag and de outside ACTIVE are ignored.
- A CLR write coincident with REPORT: the clear wins, frame_cnt=0.
- stat_* hold their value until the next REPORT.
- Reset mid-frame: everything returns to reset values. The partial frame is not reported.

Test Plan:
- Reset, write CTRL=3 and TH=100, run 3 frames of 8 lines x 16 px with 5 corr_flag pulses each. Required: dpc_en=1 and dpc_th=100 from vs_rise+1; three stat_valid pulses with stat_corr_cnt=5 and stat_line_cnt=8; frame_cnt=3.
- Write TH=40 mid-frame 1. Required: dpc_th stays 100 until frame 2 vs_rise+1, then reads 40.
- Write TH=60 in the same cycle as vs_rise. Required: that frame uses the old value; 60 appears at the following frame.
- Set run=1 while vsync is already high. Required: no counting and busy=0 until the next vs_rise. Clearing run mid-frame: the frame still reports, then IDLE and dpc_en=0.
- Drive 2^20+3 corr_flag pulses in one frame (CNT_W=20). Required: stat_corr_cnt=0xFFFFF. A CLR write in the REPORT cycle leaves frame_cnt=0.
- Assert rst mid-frame. Required: no stat_valid, all outputs at reset values, and the controller rearms only on a fresh vs_rise after run is written.
